// File: rtl/dose_pkg.sv
// rtl/dose_pkg.sv - shared state and slot definitions for the dose confirmation monitor
package dose_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2,
    MISS  = 2'd3
  } state_e;

  localparam logic [1:0] SLOT_MORNING   = 2'd0;
  localparam logic [1:0] SLOT_AFTERNOON = 2'd1;
  localparam logic [1:0] SLOT_EVENING   = 2'd2;
  localparam logic [1:0] SLOT_INVALID   = 2'd3;

  function automatic logic [2:0] slot_bit(input logic [1:0] slot);
    logic [2:0] m;
    m = 3'b000;
    case (slot)
      SLOT_MORNING:   m = 3'b001;
      SLOT_AFTERNOON: m = 3'b010;
      SLOT_EVENING:   m = 3'b100;
      default:        m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// rtl/sensor_debounce.sv - break-beam synchroniser, debouncer and falling-edge pulse
module sensor_debounce
  import dose_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic resetn,
  input  logic sensor_n,
  output logic drop_evt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          drop_q, drop_d;

  // Counter tracks how long the synchronised input has disagreed with the accepted level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    drop_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        drop_d  = level_q & ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      sync1_q <= sensor_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  assign drop_evt = drop_q;

endmodule

// File: rtl/dose_confirm_monitor.sv
// rtl/dose_confirm_monitor.sv - confirms each dispense with a pill drop; DOSE_SPURIOUS_EN adds spurious_count
module dose_confirm_monitor
  import dose_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int TIMEOUT_CYCLES  = 100000000,
  parameter int CNT_W           = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             dispense_req,
  input  logic [1:0]       slot,
  input  logic             sensor_n,
  input  logic             clear_missed,
  output logic             busy,
  output logic             confirmed,
  output logic             missed,
  output logic [2:0]       missed_mask,
  output logic [CNT_W-1:0] dose_count
`ifdef DOSE_SPURIOUS_EN
  ,
  output logic [CNT_W-1:0] spurious_count
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic drop_evt;

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock   (clock),
    .resetn  (resetn),
    .sensor_n(sensor_n),
    .drop_evt(drop_evt)
  );

  state_e           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             busy_q, busy_d;
  logic             confirmed_q, confirmed_d;
  logic             missed_q, missed_d;
  logic [2:0]       mask_q, mask_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pulses and the mask bit are produced on the transition so they line up with DONE/MISS.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    timer_d     = timer_q;
    confirmed_d = 1'b0;
    missed_d    = 1'b0;
    count_d     = count_q;
    mask_d      = clear_missed ? 3'b000 : mask_q;
    case (state_q)
      IDLE: begin
        if (dispense_req && (slot != SLOT_INVALID)) begin
          slot_d  = slot;
          timer_d = '0;
          state_d = ARMED;
        end
      end
      ARMED: begin
        timer_d = timer_q + 1'b1;
        if (drop_evt) begin
          state_d     = DONE;
          confirmed_d = 1'b1;
          if (count_q != {CNT_W{1'b1}}) count_d = count_q + 1'b1;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d  = MISS;
          missed_d = 1'b1;
          mask_d   = mask_d | slot_bit(slot_q);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == ARMED);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      slot_q      <= SLOT_MORNING;
      timer_q     <= '0;
      busy_q      <= 1'b0;
      confirmed_q <= 1'b0;
      missed_q    <= 1'b0;
      mask_q      <= 3'b000;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      timer_q     <= timer_d;
      busy_q      <= busy_d;
      confirmed_q <= confirmed_d;
      missed_q    <= missed_d;
      mask_q      <= mask_d;
      count_q     <= count_d;
    end
  end

  assign busy        = busy_q;
  assign confirmed   = confirmed_q;
  assign missed      = missed_q;
  assign missed_mask = mask_q;
  assign dose_count  = count_q;

`ifdef DOSE_SPURIOUS_EN
  logic [CNT_W-1:0] spur_q, spur_d;

  always_comb begin
    spur_d = spur_q;
    if (drop_evt && (state_q != ARMED) && (spur_q != {CNT_W{1'b1}})) spur_d = spur_q + 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) spur_q <= '0;
    else         spur_q <= spur_d;
  end

  assign spurious_count = spur_q;
`endif

endmodule

// File: tb/tb_dose_confirm_monitor.sv
// tb/tb_dose_confirm_monitor.sv - directed self-checking bench for dose_confirm_monitor
module tb_dose_confirm_monitor;
  import dose_pkg::*;

  localparam int CNT_W = 8;

  logic             clock = 1'b0;
  logic             resetn = 1'b0;
  logic             dispense_req = 1'b0;
  logic [1:0]       slot = 2'd0;
  logic             sensor_n = 1'b1;
  logic             clear_missed = 1'b0;
  logic             busy, confirmed, missed;
  logic [2:0]       missed_mask;
  logic [CNT_W-1:0] dose_count;
`ifdef DOSE_SPURIOUS_EN
  logic [CNT_W-1:0] spurious_count;
`endif

  int total = 0;
  int bad = 0;
  int exp_count = 0;

  dose_confirm_monitor #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (20),
    .CNT_W          (CNT_W)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .dispense_req  (dispense_req),
    .slot          (slot),
    .sensor_n      (sensor_n),
    .clear_missed  (clear_missed),
    .busy          (busy),
    .confirmed     (confirmed),
    .missed        (missed),
    .missed_mask   (missed_mask),
    .dose_count    (dose_count)
`ifdef DOSE_SPURIOUS_EN
    ,
    .spurious_count(spurious_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue_req(input logic [1:0] s);
    slot = s;
    dispense_req = 1'b1;
    step();
    dispense_req = 1'b0;
    slot = 2'd0;
  endtask

  task automatic drop_and_settle(input int n_low);
    sensor_n = 1'b0;
    repeat (n_low) step();
    sensor_n = 1'b1;
    repeat (8) step();
  endtask

  task automatic wait_missed(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (missed === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) step();
    total++;
    if ({busy, confirmed, missed, missed_mask, dose_count} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %0h expected 0", {busy, confirmed, missed, missed_mask, dose_count});
    end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_confirm();
    int lat;
    issue_req(SLOT_MORNING);
    repeat (2) step();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL confirm_busy: got %0b expected 1", busy);
    end
    sensor_n = 1'b0;
    lat = -1;
    for (int i = 1; i <= 15; i++) begin
      step();
      if (confirmed === 1'b1) begin
        lat = i;
        break;
      end
    end
    exp_count++;
    total++;
    if (lat != 7) begin
      bad++;
      $display("FAIL confirm_latency: got %0d expected 7", lat);
    end
    total++;
    if (dose_count !== CNT_W'(exp_count) || missed_mask !== 3'b000) begin
      bad++;
      $display("FAIL confirm_state: got count=%0d mask=%b expected count=%0d mask=000", dose_count, missed_mask, exp_count);
    end
    step();
    total++;
    if (busy !== 1'b0 || confirmed !== 1'b0) begin
      bad++;
      $display("FAIL confirm_after: got busy=%0b confirmed=%0b expected 0 0", busy, confirmed);
    end
    sensor_n = 1'b1;
    repeat (10) step();
  endtask

  task automatic test_timeout();
    int lat;
    issue_req(SLOT_EVENING);
    wait_missed(lat);
    total++;
    if (lat != 20) begin
      bad++;
      $display("FAIL timeout_latency: got %0d expected 20", lat);
    end
    total++;
    if (missed_mask !== 3'b100) begin
      bad++;
      $display("FAIL timeout_mask: got %b expected 100", missed_mask);
    end
    step();
    total++;
    if (busy !== 1'b0 || missed !== 1'b0 || dose_count !== CNT_W'(exp_count)) begin
      bad++;
      $display("FAIL timeout_after: got busy=%0b missed=%0b count=%0d expected 0 0 %0d", busy, missed, dose_count, exp_count);
    end
  endtask

  task automatic test_glitch();
    int lat;
    int conf_seen;
    clear_missed = 1'b1;
    step();
    clear_missed = 1'b0;
    total++;
    if (missed_mask !== 3'b000) begin
      bad++;
      $display("FAIL clear_mask: got %b expected 000", missed_mask);
    end
    issue_req(SLOT_AFTERNOON);
    repeat (3) step();
    sensor_n = 1'b0;
    repeat (2) step();
    sensor_n = 1'b1;
    conf_seen = 0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (confirmed === 1'b1) conf_seen++;
      if (missed === 1'b1) begin
        lat = i;
        break;
      end
    end
    total++;
    if (conf_seen != 0 || lat < 0) begin
      bad++;
      $display("FAIL glitch_ignored: got confirmed=%0d missed_at=%0d expected 0 and a miss", conf_seen, lat);
    end
    total++;
    if (missed_mask !== 3'b010) begin
      bad++;
      $display("FAIL glitch_mask: got %b expected 010", missed_mask);
    end
    step();
  endtask

  task automatic test_ignored_req();
    int lat;
    int conf_seen;
    int miss_seen;
    clear_missed = 1'b1;
    step();
    clear_missed = 1'b0;
    issue_req(SLOT_MORNING);
    repeat (2) step();
    issue_req(SLOT_AFTERNOON);
    wait_missed(lat);
    total++;
    if (lat < 0 || missed_mask !== 3'b001) begin
      bad++;
      $display("FAIL ignored_req_mask: got lat=%0d mask=%b expected 001", lat, missed_mask);
    end
    step();
    issue_req(SLOT_MORNING);
    step();
    issue_req(SLOT_AFTERNOON);
    step();
    sensor_n = 1'b0;
    conf_seen = 0;
    miss_seen = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (i == 10) sensor_n = 1'b1;
      if (confirmed === 1'b1) conf_seen++;
      if (missed === 1'b1) miss_seen++;
    end
    exp_count++;
    total++;
    if (conf_seen != 1 || miss_seen != 0 || dose_count !== CNT_W'(exp_count)) begin
      bad++;
      $display("FAIL ignored_req_confirm: got conf=%0d miss=%0d count=%0d expected 1 0 %0d", conf_seen, miss_seen, dose_count, exp_count);
    end
    issue_req(SLOT_INVALID);
    step();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL invalid_slot: got busy=%0b expected 0", busy);
    end
  endtask

  task automatic test_clear_set();
    int lat;
    issue_req(SLOT_MORNING);
    wait_missed(lat);
    step();
    issue_req(SLOT_EVENING);
    wait_missed(lat);
    step();
    total++;
    if (missed_mask !== 3'b101) begin
      bad++;
      $display("FAIL clear_set_pre: got %b expected 101", missed_mask);
    end
    issue_req(SLOT_AFTERNOON);
    repeat (19) step();
    clear_missed = 1'b1;
    step();
    clear_missed = 1'b0;
    total++;
    if (missed !== 1'b1 || missed_mask !== 3'b010) begin
      bad++;
      $display("FAIL clear_set_wins: got missed=%0b mask=%b expected 1 010", missed, missed_mask);
    end
    step();
  endtask

  task automatic test_saturate();
    while (exp_count < 255) begin
      issue_req(SLOT_MORNING);
      step();
      drop_and_settle(6);
      exp_count++;
    end
    total++;
    if (dose_count !== 8'd255) begin
      bad++;
      $display("FAIL saturate_reach: got %0d expected 255", dose_count);
    end
    issue_req(SLOT_EVENING);
    step();
    drop_and_settle(6);
    total++;
    if (dose_count !== 8'd255) begin
      bad++;
      $display("FAIL saturate_hold: got %0d expected 255", dose_count);
    end
  endtask

`ifdef DOSE_SPURIOUS_EN
  task automatic test_spurious();
    logic [CNT_W-1:0] base;
    base = spurious_count;
    repeat (3) drop_and_settle(6);
    total++;
    if (spurious_count !== base + 8'd3 || busy !== 1'b0) begin
      bad++;
      $display("FAIL spurious_count: got %0d busy=%0b expected %0d 0", spurious_count, busy, base + 8'd3);
    end
  endtask
`endif

  task automatic test_reset_mid_armed();
    int pulses;
    issue_req(SLOT_EVENING);
    repeat (5) step();
    resetn = 1'b0;
    #1;
    total++;
    if ({busy, confirmed, missed, missed_mask, dose_count} !== '0) begin
      bad++;
      $display("FAIL reset_mid_armed: got %0h expected 0", {busy, confirmed, missed, missed_mask, dose_count});
    end
    step();
    resetn = 1'b1;
    exp_count = 0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (confirmed === 1'b1 || missed === 1'b1 || busy === 1'b1) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL reset_no_pulse: got %0d active cycles expected 0", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_confirm();
    test_timeout();
    test_glitch();
    test_ignored_req();
    test_clear_set();
    test_saturate();
`ifdef DOSE_SPURIOUS_EN
    test_spurious();
`endif
    test_reset_mid_armed();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
